// File: rtl/avalon_pio_pkg.sv
// avalon_pio_pkg
// Shared constants for the Avalon-MM parallel I/O port:
//   - register word addresses on the s1 slave
//   - encodings for the EDGE_TYPE and IRQ_TYPE parameters
package avalon_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_DIR      = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK  = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP  = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/pio_sync_edge.sv
// pio_sync_edge
// Input synchroniser plus edge detector for the PIO input pins.
// Ports:
//   clk, reset_n   : system clock, asynchronous active-low reset
//   in_port        : asynchronous pin inputs (WIDTH)
//   sync_in        : in_port after SYNC_STAGES flops (WIDTH)
//   edge_pulse     : one-cycle pulse per bit on the selected edge of sync_in
module pio_sync_edge
  import avalon_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] edge_pulse
);

  // Stage 0 is the metastability-catching flop; the last stage is sync_in.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
  logic [WIDTH-1:0]                  prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
      prev  <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], in_port};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign sync_in = chain[SYNC_STAGES-1];

  always_comb begin
    edge_pulse = '0;
    case (EDGE_TYPE)
      EDGE_RISING:  edge_pulse = sync_in & ~prev;
      EDGE_FALLING: edge_pulse = ~sync_in & prev;
      default:      edge_pulse = sync_in ^ prev;
    endcase
  end

endmodule

// File: rtl/avalon_pio_ext.sv
// avalon_pio_ext
// Avalon-MM s1 parallel I/O port with per-bit direction, atomic set/clear,
// synchronised inputs, sticky edge capture and a maskable interrupt.
// Ports:
//   clk, reset_n       : system clock, asynchronous active-low reset
//   address[2:0]       : register word address
//   chipselect,write_n : write when chipselect && !write_n
//   writedata[31:0]    : write data (bits above WIDTH ignored)
//   readdata[31:0]     : combinational read data (zero latency)
//   in_port            : asynchronous pin inputs
//   out_port, out_en   : output data register and per-bit output enable
//   irq                : active-high interrupt request
module avalon_pio_ext
  import avalon_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = EDGE_RISING,
  parameter int               IRQ_TYPE    = IRQ_LEVEL
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_en,
  output logic             irq
);

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] cap_clear;
  logic [WIDTH-1:0] rd_word;
  logic             wr_en;
  logic             unused_wdata;

  pio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_port    (in_port),
    .sync_in    (sync_in),
    .edge_pulse (edge_pulse)
  );

  assign wr_en        = chipselect && !write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;
  assign cap_clear    = (wr_en && address == ADDR_EDGECAP) ? wdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_VALUE;
      dir      <= '0;
      mask     <= '0;
      edgecap  <= '0;
    end else begin
      if (wr_en) begin
        case (address)
          ADDR_DATA:     data_out <= wdata;
          ADDR_DIR:      dir      <= wdata;
          ADDR_IRQMASK:  mask     <= wdata;
          ADDR_OUTSET:   data_out <= data_out | wdata;
          ADDR_OUTCLEAR: data_out <= data_out & ~wdata;
          default:       ;
        endcase
      end
      // Clear is applied before the OR so a same-cycle edge keeps the bit set.
      edgecap <= (edgecap & ~cap_clear) | edge_pulse;
    end
  end

  // Read mux is independent of chipselect so readdata is valid with address.
  always_comb begin
    rd_word  = '0;
    case (address)
      ADDR_DATA:    rd_word = (dir & data_out) | (~dir & sync_in);
      ADDR_DIR:     rd_word = dir;
      ADDR_IRQMASK: rd_word = mask;
      ADDR_EDGECAP: rd_word = edgecap;
      default:      rd_word = '0;
    endcase
    readdata             = '0;
    readdata[WIDTH-1:0]  = rd_word;
  end

  generate
    if (IRQ_TYPE == IRQ_LEVEL) begin : g_irq_level
      assign irq = |(sync_in & mask & ~dir);
    end else begin : g_irq_edge
      assign irq = |(edgecap & mask);
    end
  endgenerate

  assign out_port = data_out;
  assign out_en   = dir;

endmodule

// File: tb/tb_avalon_pio_ext.sv
// Directed self-checking bench: an 8-bit edge-irq instance and a 32-bit
// level-irq instance share one clock. Stimulus changes on the falling edge;
// outputs are sampled 1 time unit after the falling edge.
module tb_avalon_pio_ext;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance: RESET_VALUE A5, rising edge capture, edge irq
  logic        rst_a_n;
  logic [2:0]  addr_a;
  logic        cs_a, wr_n_a;
  logic [31:0] wdata_a, rdata_a;
  logic [7:0]  in_a, out_a, oen_a;
  logic        irq_a;

  // 32-bit instance: level irq
  logic        rst_b_n;
  logic [2:0]  addr_b;
  logic        cs_b, wr_n_b;
  logic [31:0] wdata_b, rdata_b;
  logic [31:0] in_b, out_b, oen_b;
  logic        irq_b;

  int n_cmp = 0;
  int n_bad = 0;

  avalon_pio_ext #(
    .WIDTH(8), .RESET_VALUE(8'hA5), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_TYPE(1)
  ) dut_a (
    .clk(clk), .reset_n(rst_a_n), .address(addr_a), .chipselect(cs_a),
    .write_n(wr_n_a), .writedata(wdata_a), .readdata(rdata_a),
    .in_port(in_a), .out_port(out_a), .out_en(oen_a), .irq(irq_a)
  );

  avalon_pio_ext #(
    .WIDTH(32), .RESET_VALUE(32'h0), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_TYPE(0)
  ) dut_b (
    .clk(clk), .reset_n(rst_b_n), .address(addr_b), .chipselect(cs_b),
    .write_n(wr_n_b), .writedata(wdata_b), .readdata(rdata_b),
    .in_port(in_b), .out_port(out_b), .out_en(oen_b), .irq(irq_b)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end else begin
      $display("ok   %s: %h", tag, act);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic wr_a(input logic [2:0] a, input logic [31:0] d);
    addr_a = a; wdata_a = d; cs_a = 1'b1; wr_n_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cs_a = 1'b0; wr_n_a = 1'b1;
  endtask

  task automatic rd_a(input string tag, input logic [2:0] a, input logic [31:0] exp);
    addr_a = a;
    #1;
    check(tag, rdata_a, exp);
  endtask

  task automatic wr_b(input logic [2:0] a, input logic [31:0] d);
    addr_b = a; wdata_b = d; cs_b = 1'b1; wr_n_b = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cs_b = 1'b0; wr_n_b = 1'b1;
  endtask

  task automatic rd_b(input string tag, input logic [2:0] a, input logic [31:0] exp);
    addr_b = a;
    #1;
    check(tag, rdata_b, exp);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    rst_a_n = 1'b0; addr_a = 3'd0; cs_a = 1'b0; wr_n_a = 1'b1; wdata_a = '0; in_a = '0;
    rst_b_n = 1'b0; addr_b = 3'd0; cs_b = 1'b0; wr_n_b = 1'b1; wdata_b = '0; in_b = '0;

    // ---------------- reset state ----------------
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_out_port", {24'h0, out_a}, 32'h0000_00A5);
    check("rst_out_en",   {24'h0, oen_a}, 32'h0);
    check("rst_irq",      {31'h0, irq_a}, 32'h0);
    @(negedge clk);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_a($sformatf("rst_rd_addr%0d", i), 3'(i), 32'h0);
    end

    // ---------------- output path, set/clear ----------------
    wr_a(3'd1, 32'h0000_00FF);
    wr_a(3'd0, 32'hFFFF_FF3C);   // upper bits must be ignored
    check("data_3c", {24'h0, out_a}, 32'h0000_003C);
    check("dir_ff_oen", {24'h0, oen_a}, 32'h0000_00FF);
    wr_a(3'd4, 32'h0000_0081);
    check("outset_81", {24'h0, out_a}, 32'h0000_00BD);
    wr_a(3'd5, 32'h0000_000C);
    check("outclear_0c", {24'h0, out_a}, 32'h0000_00B1);
    rd_a("rd_outset_zero", 3'd4, 32'h0);
    rd_a("rd_outclear_zero", 3'd5, 32'h0);
    rd_a("rd_data_all_out", 3'd0, 32'h0000_00B1);
    wr_a(3'd6, 32'h0000_00FF);   // unmapped: no register may change
    check("addr6_no_effect", {24'h0, out_a}, 32'h0000_00B1);
    rd_a("rd_dir_ff", 3'd1, 32'h0000_00FF);

    // ---------------- mixed direction read ----------------
    wr_a(3'd1, 32'h0000_000F);
    wr_a(3'd0, 32'h0000_00AA);
    in_a = 8'h50;
    cycles(1);
    rd_a("mixed_after1", 3'd0, 32'h0000_000A);
    cycles(1);
    rd_a("mixed_after2", 3'd0, 32'h0000_005A);
    cycles(1);
    rd_a("cap_rise_50", 3'd3, 32'h0000_0050);
    in_a = 8'h00;
    cycles(4);
    rd_a("cap_fall_ignored", 3'd3, 32'h0000_0050);
    wr_a(3'd3, 32'h0000_00FF);
    rd_a("cap_cleared", 3'd3, 32'h0);

    // ---------------- edge capture irq ----------------
    wr_a(3'd2, 32'h0000_0001);
    in_a = 8'h01;
    cycles(2);
    check("edge_irq_c2", {31'h0, irq_a}, 32'h0);
    rd_a("edge_cap_c2", 3'd3, 32'h0);
    cycles(1);
    check("edge_irq_c3", {31'h0, irq_a}, 32'h1);
    rd_a("edge_cap_c3", 3'd3, 32'h0000_0001);
    wr_a(3'd3, 32'h0000_0001);
    check("edge_irq_cleared", {31'h0, irq_a}, 32'h0);
    rd_a("edge_cap_cleared", 3'd3, 32'h0);

    // ---------------- clear collides with new edge ----------------
    in_a = 8'h00;
    cycles(4);
    in_a = 8'h01;
    cycles(2);                    // edge pulse is live in this cycle
    wr_a(3'd3, 32'h0000_0001);
    rd_a("collide_cap", 3'd3, 32'h0000_0001);
    check("collide_irq", {31'h0, irq_a}, 32'h1);
    wr_a(3'd3, 32'h0000_0001);
    check("collide_then_clear", {31'h0, irq_a}, 32'h0);

    // ---------------- 32-bit level irq ----------------
    wr_b(3'd2, 32'h8000_0000);
    rd_b("w32_mask", 3'd2, 32'h8000_0000);
    in_b = 32'h8000_0000;
    cycles(1);
    check("lvl_irq_c1", {31'h0, irq_b}, 32'h0);
    cycles(1);
    check("lvl_irq_c2", {31'h0, irq_b}, 32'h1);
    rd_b("w32_rd_data", 3'd0, 32'h8000_0000);
    wr_b(3'd1, 32'hFFFF_0000);
    check("lvl_irq_dir_out", {31'h0, irq_b}, 32'h0);
    wr_b(3'd0, 32'h1234_5678);
    check("w32_out_port", out_b, 32'h1234_5678);
    check("w32_out_en", oen_b, 32'hFFFF_0000);
    rd_b("w32_mixed", 3'd0, 32'h1234_0000);
    wr_b(3'd1, 32'h0);
    check("lvl_irq_back", {31'h0, irq_b}, 32'h1);

    // ---------------- asynchronous reset mid-cycle ----------------
    addr_b = 3'd2;
    #2;
    rst_b_n = 1'b0;
    #1;
    check("arst_out_port", out_b, 32'h0);
    check("arst_out_en", oen_b, 32'h0);
    check("arst_irq", {31'h0, irq_b}, 32'h0);
    check("arst_mask", rdata_b, 32'h0);
    @(negedge clk);
    rst_b_n = 1'b1;
    cycles(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
